// File: rtl/c3lib_ckmux4_sel_ctl_if.sv
// rtl/c3lib_ckmux4_sel_ctl_if.sv - select request handshake for the clock mux select sequencer
interface c3lib_ckmux4_sel_ctl_if;
    logic       req_vld;
    logic [1:0] req_sel;
    logic       req_rdy;

    modport master (output req_vld, output req_sel, input req_rdy);
    modport slave  (input req_vld, input req_sel, output req_rdy);
endinterface

// File: rtl/c3lib_ckmux4_sel_ctl.sv
// rtl/c3lib_ckmux4_sel_ctl.sv - glitch-free select sequencer for the c3lib 4-to-1 clock mux
// Optional test override ports enabled by C3LIB_CKMUX_SEL_TST_EN.
module c3lib_ckmux4_sel_ctl #(
    parameter int DRAIN_CYC  = 4,
    parameter int SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef C3LIB_CKMUX_SEL_TST_EN
    input  logic tst_override,
    input  logic tst_s0,
    input  logic tst_s1,
`endif
    c3lib_ckmux4_sel_ctl_if.slave req,
    output logic s0,
    output logic s1,
    output logic ck_gate_en,
    output logic done_pls,
    output logic busy
);
    localparam int MAX_CYC = (DRAIN_CYC > SETTLE_CYC) ? DRAIN_CYC : SETTLE_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] DRAIN_LD  = CW'(DRAIN_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, SETTLE, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    sel_q, sel_nxt;
    logic [1:0]    tgt_q, tgt_nxt;
    logic          gate_q, gate_nxt;
    logic          done_q, done_nxt;
    logic          busy_q, busy_nxt;
    logic          rdy_q, rdy_nxt;
    logic          hold;

`ifdef C3LIB_CKMUX_SEL_TST_EN
    assign hold = tst_override;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SETTLE;
            cnt    <= SETTLE_LD;
            sel_q  <= 2'b00;
            tgt_q  <= 2'b00;
            gate_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b1;
            rdy_q  <= 1'b0;
        end else if (!hold) begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sel_q  <= sel_nxt;
            tgt_q  <= tgt_nxt;
            gate_q <= gate_nxt;
            done_q <= done_nxt;
            busy_q <= busy_nxt;
            rdy_q  <= rdy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel_q;
        tgt_nxt   = tgt_q;
        gate_nxt  = gate_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (req.req_vld && rdy_q) begin
                    tgt_nxt = req.req_sel;
                    if (req.req_sel != sel_q) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = DRAIN_LD;
                        gate_nxt  = 1'b0;
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // select may only move while the gate has been off for the full drain window
                if (cnt == '0) begin
                    sel_nxt   = tgt_q;
                    cnt_nxt   = SETTLE_LD;
                    state_nxt = SETTLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    gate_nxt  = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
        rdy_nxt  = (state_nxt == IDLE);
    end

`ifdef C3LIB_CKMUX_SEL_TST_EN
    assign s0          = tst_override ? tst_s0 : sel_q[0];
    assign s1          = tst_override ? tst_s1 : sel_q[1];
    assign ck_gate_en  = tst_override | gate_q;
    assign req.req_rdy = ~tst_override & rdy_q;
`else
    assign s0          = sel_q[0];
    assign s1          = sel_q[1];
    assign ck_gate_en  = gate_q;
    assign req.req_rdy = rdy_q;
`endif
    assign done_pls = done_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_c3lib_ckmux4_sel_ctl.sv
// tb/tb_c3lib_ckmux4_sel_ctl.sv - randomized bench for c3lib_ckmux4_sel_ctl against a timeline model
module tb_c3lib_ckmux4_sel_ctl;
    localparam int D = 4;
    localparam int S = 4;
    localparam int M_IDLE = 0, M_SW = 1, M_SAME = 2, M_RST = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ovr = 1'b0;
    logic [1:0] tst_sel = 2'b00;
    logic       s0, s1, ck_gate_en, done_pls, busy;

    c3lib_ckmux4_sel_ctl_if bus ();

    c3lib_ckmux4_sel_ctl #(.DRAIN_CYC(D), .SETTLE_CYC(S)) dut (
        .clk(clk),
        .rst(rst),
`ifdef C3LIB_CKMUX_SEL_TST_EN
        .tst_override(ovr),
        .tst_s0(tst_sel[0]),
        .tst_s1(tst_sel[1]),
`endif
        .req(bus.slave),
        .s0(s0),
        .s1(s1),
        .ck_gate_en(ck_gate_en),
        .done_pls(done_pls),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Timeline model: every sequence is a fixed schedule measured from its start edge.
    int         k = 0, k0 = 0, mode = M_IDLE;
    logic [1:0] cur = 2'b00, old_sel = 2'b00, new_sel = 2'b00;
    logic [1:0] prev_sel = 2'b00;
    logic       prev_ovr = 1'b1;
    int         n_done = 0;

    task automatic step(input logic r, input logic v, input logic [1:0] s,
                        input logic o, input logic [1:0] ts);
        int e;
        logic eg, ed, eb, er;
        logic [1:0] esel, osel;
        @(negedge clk);
        rst = r; bus.req_vld = v; bus.req_sel = s;
        ovr = o; tst_sel = ts;
        @(posedge clk);
        k++;
        if (r) begin
            mode = M_RST; k0 = k; cur = 2'b00;
        end else if (o) begin
            if (mode != M_IDLE) k0++;
        end else if (mode == M_IDLE && v) begin
            k0 = k;
            if (s != cur) begin mode = M_SW; old_sel = cur; new_sel = s; end
            else mode = M_SAME;
        end
        e = k - k0;
        eg = 1'b1; ed = 1'b0; eb = 1'b0; er = 1'b1;
        case (mode)
            M_SW: begin
                cur = (e >= D) ? new_sel : old_sel;
                if (e < D + S) begin eg = 1'b0; eb = 1'b1; er = 1'b0; end
                else begin ed = 1'b1; mode = M_IDLE; end
            end
            M_SAME: begin
                if (e == 0) begin ed = 1'b1; eb = 1'b1; er = 1'b0; end
                else mode = M_IDLE;
            end
            M_RST: begin
                if (e < S) begin eg = 1'b0; eb = 1'b1; er = 1'b0; end
                else begin ed = 1'b1; mode = M_IDLE; end
            end
            default: ;
        endcase
        esel = cur;
        if (o) begin esel = ts; eg = 1'b1; er = 1'b0; end
        #1;
        osel = {s1, s0};
        check("sel", 32'(osel), 32'(esel));
        check("ck_gate_en", 32'(ck_gate_en), 32'(eg));
        check("done_pls", 32'(done_pls), 32'(ed));
        check("busy", 32'(busy), 32'(eb));
        check("req_rdy", 32'(bus.req_rdy), 32'(er));
        if (!o && !prev_ovr && ck_gate_en)
            check("gate_on_sel_change", 32'(osel != prev_sel), 32'd0);
        if (done_pls) n_done++;
        prev_sel = osel;
        prev_ovr = o;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    endtask

    initial begin
        int d0;
        bus.req_vld = 1'b0;
        bus.req_sel = 2'b00;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        idle(S + 2);

        step(1'b0, 1'b1, 2'b10, 1'b0, 2'b00);
        idle(D + S + 1);

        step(1'b0, 1'b1, 2'b10, 1'b0, 2'b00);
        idle(2);

        step(1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        idle(D + S + 1);
        d0 = n_done;
        step(1'b0, 1'b1, 2'b01, 1'b0, 2'b00);
        idle(2);
        step(1'b0, 1'b1, 2'b11, 1'b0, 2'b00);
        idle(D + S);
        check("ignored_req_done_count", 32'(n_done - d0), 32'd1);
        check("ignored_req_final_sel", 32'({s1, s0}), 32'd1);

        step(1'b0, 1'b1, 2'b11, 1'b0, 2'b00);
        idle(D + 1);
        step(1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        idle(S + 2);

`ifdef C3LIB_CKMUX_SEL_TST_EN
        step(1'b0, 1'b1, 2'b01, 1'b0, 2'b00);
        idle(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 1'b1, 2'b11);
        idle(D + S + 2);
`endif

        for (int i = 0; i < 600; i++) begin
            logic r, v, o;
            r = ($urandom_range(0, 63) == 0);
            v = ($urandom_range(0, 1) == 1);
`ifdef C3LIB_CKMUX_SEL_TST_EN
            o = ($urandom_range(0, 15) == 0);
`else
            o = 1'b0;
`endif
            step(r, v, 2'($urandom_range(0, 3)), o, 2'($urandom_range(0, 3)));
        end
        idle(D + S + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
